// File: rtl/circle_draw_ctrl.sv
// circle_draw_ctrl: sequencer for the VGA circle datapath.
// Clears the frame buffer one pixel per cycle, then walks the midpoint
// circle algorithm and emits the eight symmetric pixels of each iteration.
// Every output is registered. Each state's outputs are loaded on the edge
// that enters that state.
module circle_draw_ctrl #(
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [6:0] radius,
  input  logic [2:0] colour,
  output logic       busy,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, INIT,
    OCT1, OCT2, OCT3, OCT4, OCT5, OCT6, OCT7, OCT8,
    STEP, DONE
  } state_t;

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
  } pix_t;

  localparam logic signed [9:0] W_LIM   = 10'(SCREEN_W);
  localparam logic signed [9:0] H_LIM   = 10'(SCREEN_H);
  localparam logic [7:0]        CX_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0]        CY_LAST = 7'(SCREEN_H - 1);

  state_t            state;
  logic [7:0]        cx_r;
  logic [6:0]        cy_r;
  logic [6:0]        rad_r;
  logic [2:0]        col_r;
  logic [7:0]        cx_cnt;
  logic [6:0]        cy_cnt;
  logic signed [9:0] ox;
  logic signed [9:0] oy;
  logic signed [9:0] crit;

  logic signed [9:0] cx_s;
  logic signed [9:0] cy_s;
  logic [7:0]        clr_nx;
  logic [6:0]        clr_ny;
  logic              clr_last;
  logic signed [9:0] step_ox;
  logic signed [9:0] step_oy;
  logic signed [9:0] step_crit;
  logic              step_cont;
  logic [2:0]        oct_sel;
  pix_t              oct_pix;
  pix_t              step_pix;

  // One octant point relative to the centre, with off-screen points masked
  // so the cycle count never depends on where the circle sits.
  function automatic pix_t oct_pixel(input logic [2:0]        oct,
                                     input logic signed [9:0] cx,
                                     input logic signed [9:0] cy,
                                     input logic signed [9:0] dx,
                                     input logic signed [9:0] dy);
    logic signed [9:0] px;
    logic signed [9:0] py;
    pix_t              p;
    case (oct)
      3'd0:    begin px = cx + dx; py = cy + dy; end
      3'd1:    begin px = cx + dy; py = cy + dx; end
      3'd2:    begin px = cx - dx; py = cy + dy; end
      3'd3:    begin px = cx - dy; py = cy + dx; end
      3'd4:    begin px = cx - dx; py = cy - dy; end
      3'd5:    begin px = cx - dy; py = cy - dx; end
      3'd6:    begin px = cx + dx; py = cy - dy; end
      default: begin px = cx + dy; py = cy - dx; end
    endcase
    p.plot = (px >= 10'sd0) && (px < W_LIM) && (py >= 10'sd0) && (py < H_LIM);
    p.x    = px[7:0];
    p.y    = py[6:0];
    return p;
  endfunction

  assign cx_s = signed'({2'b00, cx_r});
  assign cy_s = signed'({3'b000, cy_r});

  // Clear-pass scan: x inner, y outer.
  always_comb begin
    clr_last = (cx_cnt == CX_LAST) && (cy_cnt == CY_LAST);
    if (cx_cnt == CX_LAST) begin
      clr_nx = '0;
      clr_ny = cy_cnt + 7'd1;
    end else begin
      clr_nx = cx_cnt + 8'd1;
      clr_ny = cy_cnt;
    end
  end

  // Midpoint update, used both to load the registers and to pre-compute
  // the first octant pixel of the next iteration.
  always_comb begin
    step_oy = oy + 10'sd1;
    if (crit <= 10'sd0) begin
      step_ox   = ox;
      step_crit = crit + (step_oy <<< 1) + 10'sd1;
    end else begin
      step_ox   = ox - 10'sd1;
      step_crit = crit + ((step_oy - step_ox) <<< 1) + 10'sd1;
    end
    step_cont = (step_oy <= step_ox);
  end

  // Pixel for the octant state being entered next (INIT leads to OCT1).
  always_comb begin
    if (state == INIT) oct_sel = 3'd0;
    else               oct_sel = 3'(4'(state) - 4'(OCT1) + 4'd1);
    oct_pix  = oct_pixel(oct_sel, cx_s, cy_s, ox, oy);
    step_pix = oct_pixel(3'd0, cx_s, cy_s, step_ox, step_oy);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      cx_r       <= '0;
      cy_r       <= '0;
      rad_r      <= '0;
      col_r      <= '0;
      cx_cnt     <= '0;
      cy_cnt     <= '0;
      ox         <= '0;
      oy         <= '0;
      crit       <= '0;
    end else begin
      case (state)
        IDLE: begin
          vga_plot <= 1'b0;
          if (start) begin
            cx_r       <= centre_x;
            cy_r       <= centre_y;
            rad_r      <= radius;
            col_r      <= colour;
            cx_cnt     <= '0;
            cy_cnt     <= '0;
            state      <= CLEAR;
            busy       <= 1'b1;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= BG_COLOUR;
            vga_plot   <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_last) begin
            // Load the algorithm registers on entry to INIT so INIT can
            // already present the first octant pixel on its exit edge.
            state    <= INIT;
            vga_plot <= 1'b0;
            ox       <= signed'({3'b000, rad_r});
            oy       <= '0;
            crit     <= 10'sd1 - signed'({3'b000, rad_r});
          end else begin
            cx_cnt   <= clr_nx;
            cy_cnt   <= clr_ny;
            vga_x    <= clr_nx;
            vga_y    <= clr_ny;
            vga_plot <= 1'b1;
          end
        end
        INIT, OCT1, OCT2, OCT3, OCT4, OCT5, OCT6, OCT7: begin
          state      <= state_t'(4'(state) + 4'd1);
          vga_x      <= oct_pix.x;
          vga_y      <= oct_pix.y;
          vga_plot   <= oct_pix.plot;
          vga_colour <= col_r;
        end
        OCT8: begin
          state    <= STEP;
          vga_plot <= 1'b0;
        end
        STEP: begin
          ox   <= step_ox;
          oy   <= step_oy;
          crit <= step_crit;
          if (step_cont) begin
            state    <= OCT1;
            vga_x    <= step_pix.x;
            vga_y    <= step_pix.y;
            vga_plot <= step_pix.plot;
          end else begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            vga_plot <= 1'b0;
          end
        end
        DONE: begin
          vga_plot <= 1'b0;
          // Holding start keeps us here so it cannot retrigger a draw.
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          vga_plot <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_circle_draw_ctrl.sv
// Testbench for circle_draw_ctrl: randomized draws checked by a pixel
// scoreboard fed from a behavioural midpoint-circle model.
module tb_circle_draw_ctrl;

  localparam int         W  = 160;
  localparam int         H  = 120;
  localparam logic [2:0] BG = 3'b000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] centre_x = '0;
  logic [6:0] centre_y = '0;
  logic [6:0] radius = '0;
  logic [2:0] colour = '0;
  logic       busy;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pix_n = 0;

  circle_draw_ctrl #(.SCREEN_W(W), .SCREEN_H(H), .BG_COLOUR(BG)) dut (
    .clk(clk), .reset(reset), .start(start),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius), .colour(colour),
    .busy(busy), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every plotted pixel must be the next one the model predicted.
  always @(negedge clk) begin
    if (vga_plot === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot: got (%0d,%0d,%0d), required no plot at cycle %0d",
                 vga_x, vga_y, vga_colour, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (vga_x != mon_e.x || vga_y != mon_e.y || vga_colour != mon_e.c) begin
          errors++;
          $display("FAIL pixel_%0d: got (%0d,%0d,%0d), required (%0d,%0d,%0d) at cycle %0d",
                   pix_n, vga_x, vga_y, vga_colour, mon_e.x, mon_e.y, mon_e.c, cyc);
        end
      end
      pix_n++;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_now();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  function automatic void push_pix(input int x, input int y, input int c);
    pix_t p;
    p.x = x;
    p.y = y;
    p.c = c;
    exp_q.push_back(p);
  endfunction

  // Background pass: the first n pixels of a raster scan.
  function automatic void push_clear(input int n);
    for (int k = 0; k < n; k++) push_pix(k % W, k / W, int'(BG));
  endfunction

  // Midpoint circle with eight-way symmetry; returns the iteration count.
  function automatic int push_circle(input int cx, input int cy, input int r, input int c);
    int x = r;
    int y = 0;
    int d = 1 - r;
    int n = 0;
    int px, py;
    do begin
      for (int k = 0; k < 8; k++) begin
        case (k)
          0: begin px = cx + x; py = cy + y; end
          1: begin px = cx + y; py = cy + x; end
          2: begin px = cx - x; py = cy + y; end
          3: begin px = cx - y; py = cy + x; end
          4: begin px = cx - x; py = cy - y; end
          5: begin px = cx - y; py = cy - x; end
          6: begin px = cx + x; py = cy - y; end
          default: begin px = cx + y; py = cy - x; end
        endcase
        if (px >= 0 && px < W && py >= 0 && py < H) push_pix(px, py, c);
      end
      n++;
      y++;
      if (d <= 0) d = d + 2 * y + 1;
      else begin
        x--;
        d = d + 2 * (y - x) + 1;
      end
    end while (y <= x);
    return n;
  endfunction

  // One full draw: start, optional held start, then done timing checks.
  task automatic run(input int cx, input int cy, input int r, input int c, input bit hold);
    int s, n, exp_done, lim;
    centre_x = 8'(cx);
    centre_y = 7'(cy);
    radius   = 7'(r);
    colour   = 3'(c);
    start    = 1'b1;
    s        = cyc;
    push_clear(W * H);
    n        = push_circle(cx, cy, r, c);
    exp_done = s + W * H + 2 + 9 * n;
    tick();
    chk("busy_after_start", int'(busy), 1);
    chk("plot_after_start", int'(vga_plot), 1);
    if (!hold) begin
      repeat ($urandom_range(1, 4)) tick();
      start = 1'b0;
    end
    centre_x = 8'($urandom);
    centre_y = 7'($urandom);
    radius   = 7'($urandom);
    colour   = 3'($urandom);
    lim = 0;
    while (done !== 1'b1 && lim < 30000) begin
      tick();
      lim++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, required done at cycle %0d", exp_done);
      finish_now();
    end
    chk("done_cycle", cyc, exp_done);
    chk("busy_at_done", int'(busy), 0);
    chk("plots_left_at_done", exp_q.size(), 0);
    if (hold) begin
      repeat (3) begin
        tick();
        chk("done_held", int'(done), 1);
        chk("busy_held", int'(busy), 0);
      end
      start = 1'b0;
    end
    tick();
    chk("done_after_release", int'(done), 0);
    chk("busy_after_release", int'(busy), 0);
  endtask

  initial begin
    int s;
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_plot", int'(vga_plot), 0);
    chk("reset_x", int'(vga_x), 0);
    chk("reset_y", int'(vga_y), 0);
    chk("reset_colour", int'(vga_colour), 0);
    reset = 1'b0;
    tick();

    // Reset in the middle of the clear pass.
    centre_x = 8'd80;
    centre_y = 7'd60;
    radius   = 7'd5;
    colour   = 3'd7;
    start    = 1'b1;
    s        = cyc;
    push_clear(500);
    tick();
    start = 1'b0;
    while (cyc < s + 500) tick();
    reset = 1'b1;
    tick();
    chk("midclear_reset_plot", int'(vga_plot), 0);
    chk("midclear_reset_busy", int'(busy), 0);
    chk("midclear_reset_done", int'(done), 0);
    reset = 1'b0;
    repeat (20) tick();
    chk("midclear_plots_left", exp_q.size(), 0);
    chk("midclear_idle_busy", int'(busy), 0);

    // Radius 0 with start held through DONE.
    run(80, 60, 0, 2, 1'b1);
    // Radius 1, two iterations.
    run(80, 60, 1, int'($urandom_range(1, 7)), 1'b0);
    // Clipped circle near the corner.
    run(2, 2, 10, int'($urandom_range(1, 7)), 1'b0);
    // Random circle, possibly partly off-screen.
    run(int'($urandom_range(0, 175)), int'($urandom_range(0, 127)),
        int'($urandom_range(0, 40)), int'($urandom_range(0, 7)), 1'b0);

    finish_now();
  end

endmodule

// File: doc/circle_draw_ctrl.md
# circle_draw_ctrl

Sequencer for the lab2 VGA circle datapath. On `start` it clears the 160x120 frame buffer to a background colour one pixel per cycle. It then runs the midpoint circle algorithm, emitting the eight octant-symmetric pixels of each iteration one per cycle to the VGA adapter write port. It owns the centre/offset/criterion registers and the octant sequencing, so the datapath needs no separate select/load control lines.

## Interface
- `SCREEN_W`, 160, frame width in pixels; x range 0..SCREEN_W-1
- `SCREEN_H`, 120, frame height in pixels; y range 0..SCREEN_H-1
- `BG_COLOUR`, 3'b000, colour written during the clear pass
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  level request; sampled only in IDLE
- `centre_x`  in  8  circle centre x; captured when start is accepted
- `centre_y`  in  7  circle centre y; captured when start is accepted
- `radius`  in  7  circle radius; captured when start is accepted
- `colour`  in  3  circle colour; captured when start is accepted
- `busy`  out  1  high in every state except IDLE and DONE
- `done`  out  1  high while in DONE
- `vga_x`  out  8  pixel x to adapter
- `vga_y`  out  7  pixel y to adapter
- `vga_colour`  out  3  pixel colour to adapter
- `vga_plot`  out  1  write strobe; adapter writes (vga_x, vga_y, vga_colour) when high

## Operation
- States: IDLE, CLEAR, INIT, OCT1..OCT8, STEP, DONE.
- IDLE: if `start`=1, capture the inputs and go to CLEAR with the clear counters at (0,0).
- CLEAR: emits (cx_cnt, cy_cnt, BG_COLOUR) with vga_plot=1 each cycle.
  - Scan order: x inner, y outer.
  - After (SCREEN_W-1, SCREEN_H-1), go to INIT.
- INIT: sets ox=radius, oy=0, crit=1-radius; vga_plot=0; go to OCT1.
- OCT1..OCT8: one pixel per state, in this order:
  - OCT1 (cx+ox, cy+oy), OCT2 (cx+oy, cy+ox)
  - OCT3 (cx-ox, cy+oy), OCT4 (cx-oy, cy+ox)
  - OCT5 (cx-ox, cy-oy), OCT6 (cx-oy, cy-ox)
  - OCT7 (cx+ox, cy-oy), OCT8 (cx+oy, cy-ox)
  - Colour is the captured `colour`. OCT8 goes to STEP.
- STEP: vga_plot=0.
  - oy <= oy+1.
  - If crit<=0: crit <= crit + 2*(oy+1) + 1.
  - Otherwise: ox <= ox-1 and crit <= crit + 2*((oy+1)-(ox-1)) + 1.
  - Next state: if (oy+1) <= (ox after update), go to OCT1; else go to DONE.
- DONE: done=1. Stay while `start`=1; go to IDLE when `start`=0. This prevents a held start from retriggering.
- Arithmetic: coordinates are computed as 10-bit signed values; crit, ox and oy are 10-bit signed.
- Clipping: if a computed point has x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H, then vga_plot=0 for that cycle. The state still advances, so cycle count is independent of position.
- Duplicate pixels (e.g. ox==oy, or oy==0) are plotted again, not suppressed.
- `start` asserted outside IDLE is ignored. Input changes after capture have no effect.

## Timing
- All outputs are registered.
- Reset (sync): state=IDLE. busy=0, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0. Internal counters and registers are cleared.
- Reset wins over every other condition, including mid-CLEAR or mid-octant. The next cycle is IDLE with no further plots.
- Cycle S: `start`=1 sampled in IDLE. From S+1, busy=1 and the first clear pixel (0,0) has vga_plot=1.
- Clear occupies cycles S+1..S+SCREEN_W*SCREEN_H (S+19200 with defaults). INIT is at S+19201.
- Each algorithm iteration takes 9 cycles: 8 octant cycles plus 1 STEP.
- With N iterations, DONE is entered at S+19201+9N+1. done rises and busy falls on that cycle.
- Minimum N=1 (radius 0). Radius 0 gives 8 plots, all at the centre.

## Test plan
- Reset mid-CLEAR: assert reset at S+500 -> next cycle vga_plot=0, busy=0, state IDLE. No plot follows without a new start.
- Clear pass: start with defaults -> exactly 19200 cycles with vga_plot=1 and colour BG_COLOUR. First pixel (0,0), 161st pixel (0,1), last pixel (159,119), each coordinate exactly once.
- Radius 0 at (80,60), colour 3'b010 -> after clear, 8 plots all at (80,60). done rises at S+19211.
- Radius 1 at (80,60) -> 2 iterations, 16 plots. The first 8 are (81,60) (80,61) (79,60) (80,61) (79,60) (80,59) (81,60) (80,59). done at S+19220.
- Clipping: centre (2,2), radius 10 -> points with negative coordinates have vga_plot=0. The total cycle count equals that of the unclipped centre (80,60), radius 10.
- Start held high through DONE -> remains in DONE with done=1. Dropping start gives IDLE next cycle, and re-asserting it starts a new clear.
